// File: rtl/ahb_pkg.sv
// Shared AHB encodings and helpers.
// Used by the arbiter and its round-robin picker.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;
  localparam logic [2:0] HB_WRAP4  = 3'd2;
  localparam logic [2:0] HB_INCR4  = 3'd3;
  localparam logic [2:0] HB_WRAP8  = 3'd4;
  localparam logic [2:0] HB_INCR8  = 3'd5;
  localparam logic [2:0] HB_WRAP16 = 3'd6;
  localparam logic [2:0] HB_INCR16 = 3'd7;

  // SEQ beats still owed after the NONSEQ of a fixed burst
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] n;
    case (hburst)
      HB_WRAP4,  HB_INCR4:  n = 4'd3;
      HB_WRAP8,  HB_INCR8:  n = 4'd7;
      HB_WRAP16, HB_INCR16: n = 4'd15;
      default:              n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_rr_select.sv
// Round-robin picker: first requester at or after start,
// wrapping; default_idx when nobody requests.
module ahb_rr_select #(
  parameter int N  = 3,
  parameter int MW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] start,
  input  logic [MW-1:0] default_idx,
  output logic [MW-1:0] winner,
  output logic          any
);

  int j;

  // scan backwards so the lowest offset from start is written last
  always_comb begin
    winner = default_idx;
    any    = 1'b0;
    j      = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(start) + i;
      if (j >= N) j = j - N;
      if (req[j[MW-1:0]]) begin
        winner = j[MW-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with burst/lock protection
// and parking on a default master.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 3,
  parameter  int DEFAULT_MASTER = 0,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock
);

  localparam logic [MW-1:0] DEF = MW'(DEFAULT_MASTER);
  localparam logic [MW-1:0] LAST = MW'(NUM_MASTERS - 1);

  logic [MW-1:0] g_idx;
  logic [MW-1:0] g_nxt;
  logic [MW-1:0] start;
  logic [MW-1:0] winner;
  logic [3:0]    rem;
  logic [3:0]    rem_nxt;
  logic          any;
  logic          arb_ok;

  assign start = (hmaster == LAST) ? '0 : hmaster + 1'b1;

  ahb_rr_select #(
    .N  (NUM_MASTERS),
    .MW (MW)
  ) u_sel (
    .req         (hbusreq),
    .start       (start),
    .default_idx (DEF),
    .winner      (winner),
    .any         (any)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      g_idx     <= DEF;
      hmaster   <= DEF;
      hmastlock <= 1'b0;
      rem       <= '0;
    end else if (hready) begin
      g_idx     <= g_nxt;
      hmaster   <= g_idx;
      hmastlock <= hlock[g_idx];
      rem       <= rem_nxt;
    end
  end

  always_comb begin
    rem_nxt = rem;
    if (hready) begin
      case (htrans_e'(htrans))
        NONSEQ:  rem_nxt = burst_beats(hburst);
        SEQ:     if (rem != '0) rem_nxt = rem - 4'd1;
        BUSY:    rem_nxt = rem;
        default: rem_nxt = '0;
      endcase
    end
    // grant may only move once the owed beats are all taken
    arb_ok = hready & ~hlock[g_idx] & (rem_nxt == '0);
    g_nxt  = g_idx;
    if (arb_ok) g_nxt = any ? winner : DEF;
  end

  always_comb begin
    hgrant        = '0;
    hgrant[g_idx] = 1'b1;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin AHB bus arbiter that shares the single AHB slave port of `bridge_top` among up to `NUM_MASTERS` AHB masters. It issues `hgrant`, tracks bus ownership in `hmaster` and the lock indication in `hmastlock`. Fixed-length bursts and locked sequences are never broken, and the bus is parked on a default master when no master is requesting. The master-side address/control/data mux is steered by `hmaster`, and the bridge sees that mux output.

## Interface
- `NUM_MASTERS`, 3: number of requesting masters, range 2..8.
- `DEFAULT_MASTER`, 0: park/default master index, less than `NUM_MASTERS`.
- `MW`, derived: `max(1, $clog2(NUM_MASTERS))`, the width of `hmaster`.
- `hclk` (in, 1): the block's one clock; all logic is on the rising edge.
- `hreset` (in, 1): synchronous reset, active-high.
- `hbusreq` (in, `NUM_MASTERS`): per-master bus request.
- `hlock` (in, `NUM_MASTERS`): per-master lock request.
- `htrans` (in, 2): the muxed bus HTRANS of the current owner.
- `hburst` (in, 3): the muxed bus HBURST of the current owner.
- `hready` (in, 1): bus HREADY, taken from the bridge `hr_readyout`.
- `hgrant` (out, `NUM_MASTERS`): one-hot grant, registered.
- `hmaster` (out, `MW`): index of the current address-phase owner, registered.
- `hmastlock` (out, 1): the current transfer is part of a locked sequence, registered.

## Operation
- Reset values:
  - `hgrant` is one-hot at `DEFAULT_MASTER`.
  - `hmaster` = `DEFAULT_MASTER`.
  - `hmastlock` = 0.
  - Beat counter `rem` = 0.
  - Round-robin pointer = `DEFAULT_MASTER`.
- Beat counter `rem` (4 bits) counts the SEQ beats still owed by a fixed burst. It updates only when `hready`=1:
  - NONSEQ with INCR4/WRAP4 loads 3.
  - NONSEQ with INCR8/WRAP8 loads 7.
  - NONSEQ with INCR16/WRAP16 loads 15.
  - NONSEQ with SINGLE/INCR loads 0.
  - SEQ with `rem`>0 decrements `rem`.
  - BUSY holds `rem`.
  - IDLE clears `rem` to 0 (the burst is abandoned).
- `rem_nxt` is the value `rem` takes at the next edge.
- Arbitration point: `arb_ok = hready & ~hlock[g] & (rem_nxt == 0)`, where `g` is the currently granted index.
- Selection, applied only when `arb_ok`:
  - Scan `hbusreq` starting at `hmaster+1`, wrapping modulo `NUM_MASTERS`; the first requester wins.
  - The current owner wins only if no other master is requesting.
  - If no master is requesting, grant `DEFAULT_MASTER`.
- States:
  - PARK: the default master is granted and nobody is requesting.
  - OWNED: a requester is granted and the grant is movable at `arb_ok`.
  - BURST: `rem`≠0, so the grant is frozen.
  - LOCKED: `hlock[g]`=1, so the grant is frozen.
  - The state is derived from the registers; no separate encoding is needed.
- Ownership handover: at every edge where `hready`=1, `hmaster` ← index(`hgrant`) and `hmastlock` ← `hlock[index(hgrant)]`. `hmaster` therefore trails `hgrant` by one accepted cycle, which is standard AHB handover.
- When `hready`=0, `hgrant`, `hmaster`, `hmastlock` and `rem` all hold.
- A request dropped mid-burst has no effect; the grant holds until `rem_nxt`=0.
- Simultaneous requests are resolved by round-robin order only; there are no fixed priorities.
- Reset asserted mid-burst or mid-lock returns all registers to their reset values at that edge.

## Timing
- Grant latency: a request raised in cycle N with `arb_ok` in N gives `hgrant` in N+1. `hmaster` follows at the first `hready`=1 edge after that, so the earliest is N+2.
- INCR4 owner: NONSEQ is accepted at edge E0 and the SEQ beats at E1, E2, E3. `rem_nxt` reaches 0 in the cycle ending at E3, so `hgrant` may move at E3 and no earlier.
- Wait states (`hready`=0) stretch every step above cycle-for-cycle.
- No combinational path from any input to any output.

## Structure
- Shared package `ahb_pkg`:
  - HTRANS codes: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HBURST codes 0..7.
  - Function `burst_beats(hburst)` returning 0/3/7/15.
- Sub-module `ahb_rr_select`: combinational picker taking `req`, `start`, `default_idx` and returning `winner` and `any`.

## Test plan
- Reset, then `hbusreq`=0 -> `hgrant`=3'b001, `hmaster`=0, `hmastlock`=0, held for 10 cycles.
- `hbusreq`=3'b110 from reset and `hready`=1 -> grant goes to 1 first. Master 1 issues one SINGLE NONSEQ and then IDLE -> grant goes to 2 -> then back to 1 while both keep requesting.
- Master 1 runs INCR4 with `hbusreq[2]`=1 throughout -> `hgrant` stays 3'b010 until the edge accepting the third SEQ, then 3'b100. `hmaster`=2 one `hready` edge later.
- Same INCR4 with `hready`=0 for 2 cycles mid-burst -> handover delayed by exactly 2 cycles. BUSY beats do not decrement `rem`.
- Master 0 asserts `hlock[0]` across 3 SINGLE transfers while master 1 requests -> grant stays at 0 and `hmastlock`=1 for all three transfers. The grant moves to 1 one cycle after `hlock[0]` falls.
- `hreset` pulsed during master 2's INCR8 at `rem`=5 -> next cycle `hgrant`=3'b001, `hmaster`=0, `rem`=0.
